lsu_ctrl: RTL

Load/store initiator between the execute stage and the word-organised data memory. Accepts one RV32 load or store per request, turns a 7-bit byte address into a 5-bit word address plus byte mask, replicates store data into byte lanes, and extracts and sign- or zero-extends load data from the returned word. A small FSM sequences each access and returns a single-cycle response with an error flag for misaligned or illegal accesses.

---
 rtl/lsu_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store initiator: sequences one RV32 load or store against a 32x32 word
// memory, handling byte-lane masking, store replication and load extension.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wren,
  output logic        mem_is_load,
  output logic [3:0]  mem_mask,
  output logic [4:0]  mem_w_addr,
  output logic [4:0]  mem_r_addr,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_STORE   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]  state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [6:0]  addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        req_bad;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_fmt;

  assign accept = req_valid && req_ready;

  always_comb begin
    req_bad = 1'b0;
    if (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7)
      req_bad = 1'b1;
    if (req_we && req_funct3 > 3'd2)
      req_bad = 1'b1;
    if (req_funct3[1:0] == 2'd1 && req_addr[0])
      req_bad = 1'b1;
    if (req_funct3 == 3'd2 && req_addr[1:0] != 2'd0)
      req_bad = 1'b1;
  end

  always_comb begin
    load_byte = mem_r_data[8*addr_q[1:0] +: 8];
    load_half = addr_q[1] ? mem_r_data[31:16] : mem_r_data[15:0];
    case (funct3_q)
      3'd0:    load_fmt = {{24{load_byte[7]}}, load_byte};
      3'd4:    load_fmt = {24'd0, load_byte};
      3'd1:    load_fmt = {{16{load_half[15]}}, load_half};
      3'd5:    load_fmt = {16'd0, load_half};
      default: load_fmt = mem_r_data;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 7'd0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= req_bad;
            rdata_q  <= 32'd0;
            if (req_bad)     state <= S_RESP;
            else if (req_we) state <= S_STORE;
            else             state <= S_LOAD;
          end
        end
        S_STORE:   state <= S_RESP;
        S_LOAD:    state <= S_CAPTURE;
        S_CAPTURE: begin
          rdata_q <= load_fmt;
          state   <= S_RESP;
        end
        S_RESP:    state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Store strobes are not gated by rst_n so a STORE cycle coinciding with the
  // reset edge still commits; everything else drops immediately in reset.
  assign mem_wren    = (state == S_STORE);
  assign mem_is_load = rst_n && (state == S_LOAD);
  assign req_ready   = rst_n && (state == S_IDLE);
  assign resp_valid  = rst_n && (state == S_RESP);
  assign resp_err    = resp_valid && err_q;
  assign resp_rdata  = rdata_q;
  assign mem_w_addr  = addr_q[6:2];
  assign mem_r_addr  = addr_q[6:2];

  // NOTE: defaults first so no path through the case leaves an output unassigned
  // (which would infer a latch).
  always_comb begin
    mem_mask   = 4'b0000;
    mem_w_data = 32'd0;
    if (state == S_STORE) begin
      case (funct3_q[1:0])
        2'd0: begin
          mem_mask   = 4'b0001 << addr_q[1:0];
          mem_w_data = {4{wdata_q[7:0]}};
        end
        2'd1: begin
          mem_mask   = addr_q[1] ? 4'b1100 : 4'b0011;
          mem_w_data = {2{wdata_q[15:0]}};
        end
        default: begin
          mem_mask   = 4'b1111;
          mem_w_data = wdata_q;
        end
      endcase
    end
  end

  // we_q is kept for debug visibility of the accepted request type.
  logic unused_we;
  assign unused_we = we_q;

endmodule
